// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART bridge: byte width, TX sequencer state encoding
// and the default host trigger byte.
package uart_bridge_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam int unsigned DEF_TRIG_BYTE = 32'h0000_0041;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_ARM  = 2'd1,
    SEQ_BUSY = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO. A push and a pop in the same cycle both succeed even
// when full; a push while full with no pop is refused and the caller sees o_full.
module sync_byte_fifo
  import uart_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  byte_t i_data,
  input  logic  i_pop,
  output byte_t o_data,
  output logic  o_full,
  output logic  o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_byte_fifo: DEPTH must be a power of two in 2..256");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  byte_t         r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1'b1);
        2'b01:   r_count <= r_count - (AW+1)'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/uart_bridge_core.sv
// Bidirectional UART byte bridge: host<->target FIFOs with per-direction TX sequencers.
// Optional target-reset trigger on a host byte, enabled by macro UART_BRIDGE_RST_TRIG_EN.
module uart_bridge_core
  import uart_bridge_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TRIG_BYTE  = DEF_TRIG_BYTE,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  byte_t h_rx_data,
  input  logic  h_rx_valid,
  input  byte_t t_rx_data,
  input  logic  t_rx_valid,
  input  logic  t_tx_rdy,
  output logic  t_tx_en,
  output byte_t t_tx_data,
  input  logic  h_tx_rdy,
  output logic  h_tx_en,
  output byte_t h_tx_data,
  output logic  target_rst_n,
  output logic  led,
  output logic  h_ovf,
  output logic  t_ovf
);

  if ((RST_CYCLES < 1) || (TRIG_BYTE > 32'd255)) begin : g_bad_cfg
    $error("uart_bridge_core: RST_CYCLES must be >= 1 and TRIG_BYTE must fit a byte");
  end

  // Path 0 carries host->target, path 1 carries target->host.
  logic [1:0] w_push;
  logic [1:0] w_rdy;
  byte_t      w_din [2];
  logic [1:0] w_tx_en;
  byte_t      w_tx_data [2];
  logic [1:0] w_ovf;

  assign w_push   = {t_rx_valid, h_rx_valid};
  assign w_rdy    = {h_tx_rdy, t_tx_rdy};
  assign w_din[0] = h_rx_data;
  assign w_din[1] = t_rx_data;

  for (genvar g = 0; g < 2; g++) begin : g_path
    seq_state_t r_state;
    seq_state_t w_state_nxt;
    logic       r_seen_low;
    logic       w_seen_nxt;
    logic       w_arm;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    byte_t      w_head;
    logic       r_tx_en;
    byte_t      r_tx_data;
    logic       r_ovf;

    sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_data  (w_din[g]),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
    );

    assign w_pop = (r_state == SEQ_ARM);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= SEQ_IDLE;
        r_seen_low <= 1'b0;
        r_tx_en    <= 1'b0;
        r_tx_data  <= 8'h00;
        r_ovf      <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_seen_low <= w_seen_nxt;
        r_tx_en    <= w_arm;
        // The head captured on entry to ARM is the byte popped in ARM.
        if (w_arm) begin
          r_tx_data <= w_head;
        end else begin
          r_tx_data <= r_tx_data;
        end
        r_ovf <= r_ovf | (w_push[g] && w_full && !w_pop);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_seen_nxt  = r_seen_low;
      w_arm       = 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (!w_empty && w_rdy[g]) begin
            w_state_nxt = SEQ_ARM;
            w_arm       = 1'b1;
          end else begin
            w_state_nxt = SEQ_IDLE;
          end
        end
        SEQ_ARM: begin
          w_state_nxt = SEQ_BUSY;
          w_seen_nxt  = 1'b0;
        end
        SEQ_BUSY: begin
          // Wait for the transmitter to report busy, then idle again.
          if (w_rdy[g] && r_seen_low) begin
            w_state_nxt = SEQ_IDLE;
          end else if (!w_rdy[g]) begin
            w_seen_nxt = 1'b1;
          end else begin
            w_state_nxt = SEQ_BUSY;
          end
        end
        default: begin
          w_state_nxt = SEQ_IDLE;
          w_seen_nxt  = 1'b0;
        end
      endcase
    end

    assign w_tx_en[g]   = r_tx_en;
    assign w_tx_data[g] = r_tx_data;
    assign w_ovf[g]     = r_ovf;
  end

  assign t_tx_en   = w_tx_en[0];
  assign t_tx_data = w_tx_data[0];
  assign h_ovf     = w_ovf[0];
  assign h_tx_en   = w_tx_en[1];
  assign h_tx_data = w_tx_data[1];
  assign t_ovf     = w_ovf[1];

`ifdef UART_BRIDGE_RST_TRIG_EN
  localparam int unsigned CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = RST_CYCLES[CW-1:0];

  logic          w_trig;
  logic [CW-1:0] r_rst_cnt;
  logic          r_target_rst_n;
  logic          r_led;

  // Triggers are taken from the raw strobe so a byte dropped by a full FIFO still fires.
  assign w_trig = h_rx_valid && (h_rx_data == TRIG_BYTE[BYTE_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_cnt      <= {CW{1'b0}};
      r_target_rst_n <= 1'b1;
      r_led          <= 1'b0;
    end else if (w_trig) begin
      r_rst_cnt      <= CNT_LOAD;
      r_target_rst_n <= 1'b0;
      r_led          <= ~r_led;
    end else if (r_rst_cnt != {CW{1'b0}}) begin
      r_rst_cnt      <= r_rst_cnt - CW'(1'b1);
      r_target_rst_n <= (r_rst_cnt == CW'(1'b1));
      r_led          <= r_led;
    end else begin
      r_rst_cnt      <= r_rst_cnt;
      r_target_rst_n <= 1'b1;
      r_led          <= r_led;
    end
  end

  assign target_rst_n = r_target_rst_n;
  assign led          = r_led;
`else
  assign target_rst_n = 1'b1;
  assign led          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bridge_core.sv
// Scoreboard bench for uart_bridge_core: stimulus pushes expected bytes per path,
// a negedge monitor pops and compares on every tx_en strobe.
module tb_uart_bridge_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] h_rx_data, t_rx_data;
  logic       h_rx_valid, t_rx_valid;
  logic       t_tx_rdy, h_tx_rdy;
  logic       t_tx_en, h_tx_en;
  logic [7:0] t_tx_data, h_tx_data;
  logic       target_rst_n, led, h_ovf, t_ovf;

  logic       t_hold, h_hold;
  logic [2:0] t_busy = 3'd0;
  logic [2:0] h_busy = 3'd0;
  int         low_cnt = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_t [$];
  logic [7:0] exp_h [$];
  logic [7:0] e_t, e_h;

  always #5 clk = ~clk;

  uart_bridge_core dut (
    .clk          (clk),
    .rst          (rst),
    .h_rx_data    (h_rx_data),
    .h_rx_valid   (h_rx_valid),
    .t_rx_data    (t_rx_data),
    .t_rx_valid   (t_rx_valid),
    .t_tx_rdy     (t_tx_rdy),
    .t_tx_en      (t_tx_en),
    .t_tx_data    (t_tx_data),
    .h_tx_rdy     (h_tx_rdy),
    .h_tx_en      (h_tx_en),
    .h_tx_data    (h_tx_data),
    .target_rst_n (target_rst_n),
    .led          (led),
    .h_ovf        (h_ovf),
    .t_ovf        (t_ovf)
  );

  // Transmitter models: busy for three cycles after each start strobe.
  always @(posedge clk) begin
    if (t_tx_en) t_busy <= 3'd3;
    else if (t_busy != 3'd0) t_busy <= t_busy - 3'd1;
    if (h_tx_en) h_busy <= 3'd3;
    else if (h_busy != 3'd0) h_busy <= h_busy - 3'd1;
  end
  assign t_tx_rdy = (t_busy == 3'd0) && !t_hold;
  assign h_tx_rdy = (h_busy == 3'd0) && !h_hold;

  always @(negedge clk) begin
    if (!target_rst_n) low_cnt <= low_cnt + 1;
  end

  // Monitor: every transmitted byte must match the head of its path's queue.
  always @(negedge clk) begin
    if (t_tx_en) begin
      total++;
      if (exp_t.size() == 0) begin
        bad++;
        $display("FAIL t_tx_byte: got %02h, required no byte", t_tx_data);
      end else begin
        e_t = exp_t.pop_front();
        if (t_tx_data !== e_t) begin
          bad++;
          $display("FAIL t_tx_byte: got %02h, required %02h", t_tx_data, e_t);
        end
      end
    end
    if (h_tx_en) begin
      total++;
      if (exp_h.size() == 0) begin
        bad++;
        $display("FAIL h_tx_byte: got %02h, required no byte", h_tx_data);
      end else begin
        e_h = exp_h.pop_front();
        if (h_tx_data !== e_h) begin
          bad++;
          $display("FAIL h_tx_byte: got %02h, required %02h", h_tx_data, e_h);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_h(input logic [7:0] b, input bit fwd);
    h_rx_data  = b;
    h_rx_valid = 1'b1;
    tick(1);
    h_rx_valid = 1'b0;
    if (fwd) exp_t.push_back(b);
  endtask

  task automatic push_t(input logic [7:0] b, input bit fwd);
    t_rx_data  = b;
    t_rx_valid = 1'b1;
    tick(1);
    t_rx_valid = 1'b0;
    if (fwd) exp_h.push_back(b);
  endtask

  task automatic push_both(input logic [7:0] hb, input logic [7:0] tb);
    h_rx_data  = hb;
    t_rx_data  = tb;
    h_rx_valid = 1'b1;
    t_rx_valid = 1'b1;
    tick(1);
    h_rx_valid = 1'b0;
    t_rx_valid = 1'b0;
    exp_t.push_back(hb);
    exp_h.push_back(tb);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_t.size() != 0 || exp_h.size() != 0) && n < 3000) begin
      tick(1);
      n++;
    end
    check(name, exp_t.size() + exp_h.size(), 0);
    tick(12);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_t.delete();
    exp_h.delete();
    tick(1);
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_t_en"}, t_tx_en, 1'b0);
    check({tag, "_h_en"}, h_tx_en, 1'b0);
    check({tag, "_t_data"}, t_tx_data, 8'h00);
    check({tag, "_h_data"}, h_tx_data, 8'h00);
    check({tag, "_h_ovf"}, h_ovf, 1'b0);
    check({tag, "_t_ovf"}, t_ovf, 1'b0);
    check({tag, "_led"}, led, 1'b0);
    check({tag, "_trst_n"}, target_rst_n, 1'b1);
  endtask

  initial begin
    int base;
    logic [7:0] hb, tb;
    t_hold = 1'b0;
    h_hold = 1'b0;
    h_rx_data = 8'h00;
    t_rx_data = 8'h00;
    h_rx_valid = 1'b0;
    t_rx_valid = 1'b0;

    // Reset with strobes asserted: strobes must be ignored.
    rst = 1'b1;
    tick(1);
    h_rx_data = 8'h41;
    t_rx_data = 8'h77;
    h_rx_valid = 1'b1;
    t_rx_valid = 1'b1;
    tick(2);
    h_rx_valid = 1'b0;
    t_rx_valid = 1'b0;
    rst = 1'b0;
    tick(1);
    check_idle_state("reset");
    check("reset_trst_low_cnt", low_cnt, 0);
    tick(10);

    // Single byte latency and data hold.
    push_h(8'h55, 1'b1);
    check("lat_cycle1_en", t_tx_en, 1'b0);
    tick(1);
    check("lat_cycle2_en", t_tx_en, 1'b1);
    check("lat_cycle2_data", t_tx_data, 8'h55);
    tick(1);
    check("en_one_cycle", t_tx_en, 1'b0);
    check("data_hold", t_tx_data, 8'h55);
    push_t(8'hC3, 1'b1);
    drain("drain_single");
    check("h_data_hold", h_tx_data, 8'hC3);

    // Backpressure and overflow on the host->target path.
    do_reset();
    t_hold = 1'b1;
    for (int i = 0; i < 16; i++) push_h(8'(i), 1'b1);
    check("bp_no_ovf_at_full", h_ovf, 1'b0);
    push_h(8'h10, 1'b0);
    check("bp_h_ovf", h_ovf, 1'b1);
    check("bp_t_ovf", t_ovf, 1'b0);
    tick(3);
    t_hold = 1'b0;
    drain("drain_bp");
    check("bp_last_byte", t_tx_data, 8'h0F);
    check("bp_ovf_sticky", h_ovf, 1'b1);

    // Full FIFO: push in the ARM cycle succeeds, occupancy stays at 16.
    do_reset();
    check("full_ovf_cleared", h_ovf, 1'b0);
    t_hold = 1'b1;
    for (int i = 0; i < 16; i++) push_h(8'(8'h20 + i), 1'b1);
    t_hold = 1'b0;
    tick(1);
    check("full_arm_en", t_tx_en, 1'b1);
    push_h(8'h30, 1'b1);
    t_hold = 1'b1;
    check("full_pushpop_no_ovf", h_ovf, 1'b0);
    push_h(8'h31, 1'b0);
    check("full_still_16", h_ovf, 1'b1);
    t_hold = 1'b0;
    drain("drain_full");
    check("full_last_byte", t_tx_data, 8'h30);

    // Trigger byte handling.
    do_reset();
`ifdef UART_BRIDGE_RST_TRIG_EN
    base = low_cnt;
    push_h(8'h41, 1'b1);
    check("trig_next_cycle_low", target_rst_n, 1'b0);
    check("trig_led_on", led, 1'b1);
    tick(30);
    check("trig_pulse_len", low_cnt - base, 16);
    check("trig_released", target_rst_n, 1'b1);
    base = low_cnt;
    push_h(8'h41, 1'b1);
    check("trig_led_off", led, 1'b0);
    tick(9);
    push_h(8'h41, 1'b1);
    check("retrig_led_on", led, 1'b1);
    tick(40);
    check("retrig_pulse_len", low_cnt - base, 26);
    // A dropped trigger still pulses the target reset.
    t_hold = 1'b1;
    for (int i = 0; i < 16; i++) push_h(8'(8'h60 + i), 1'b1);
    base = low_cnt;
    push_h(8'h41, 1'b0);
    check("drop_trig_ovf", h_ovf, 1'b1);
    check("drop_trig_led", led, 1'b0);
    tick(30);
    check("drop_trig_pulse_len", low_cnt - base, 16);
    t_hold = 1'b0;
`else
    base = low_cnt;
    push_h(8'h41, 1'b1);
    tick(20);
    check("notrig_trst_n", target_rst_n, 1'b1);
    check("notrig_led", led, 1'b0);
    check("notrig_low_cnt", low_cnt - base, 0);
`endif
    drain("drain_trig");

    // Bidirectional random streams, spaced so neither FIFO overflows.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      hb = 8'($urandom);
      tb = 8'($urandom);
      push_both(hb, tb);
      tick(int'($urandom_range(6, 9)));
    end
    drain("drain_bidir");
    check("bidir_h_ovf", h_ovf, 1'b0);
    check("bidir_t_ovf", t_ovf, 1'b0);

    // Reset mid-operation discards queued bytes and clears flags.
    t_hold = 1'b1;
    h_hold = 1'b1;
    for (int i = 0; i < 17; i++) push_t(8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 5; i++) push_h(8'(8'hA0 + i), 1'b1);
    check("mid_t_ovf_set", t_ovf, 1'b1);
    rst = 1'b1;
    exp_t.delete();
    exp_h.delete();
    h_rx_data = 8'h41;
    h_rx_valid = 1'b1;
    tick(2);
    h_rx_valid = 1'b0;
    rst = 1'b0;
    t_hold = 1'b0;
    h_hold = 1'b0;
    tick(40);
    check_idle_state("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_bridge_core.md
UART_BRIDGE_CORE -- requirements
Module: uart_bridge_core

Interface
REQ-001 Parameter DEPTH, default 16, per-direction FIFO depth in bytes; power of two, 2..256.
REQ-002 Parameter TRIG_BYTE, default 8'h41, host byte that triggers a target reset.
REQ-003 Parameter RST_CYCLES, default 16, target reset pulse length in clk cycles; minimum 1.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 h_rx_data  in  8  byte from the host-side receiver.
REQ-007 h_rx_valid  in  1  one-cycle strobe; h_rx_data is valid.
REQ-008 t_rx_data / t_rx_valid  in  8/1  same pair, from the target-side receiver.
REQ-009 t_tx_rdy  in  1  target-side transmitter is idle.
REQ-010 t_tx_en / t_tx_data  out  1/8  start strobe and byte for the target-side transmitter.
REQ-011 h_tx_rdy / h_tx_en / h_tx_data  in/out/out  1/1/8  same triple, for the host-side transmitter.
REQ-012 target_rst_n  out  1  active-low target reset.
REQ-013 led  out  1  toggles on each trigger byte.
REQ-014 h_ovf / t_ovf  out  1/1  sticky flags: a byte was dropped in the host-to-target / target-to-host FIFO.

Function
REQ-015 Host-to-target path SHALL be h_rx -> FIFO -> t_tx; target-to-host path SHALL be t_rx -> FIFO -> h_tx; the two paths are independent.
REQ-016 A valid strobe SHALL push its byte in the same cycle; the byte SHALL be readable from the FIFO in the next cycle.
REQ-017 Push while full SHALL drop the byte, leave FIFO contents unchanged and set the path's ovf flag.
REQ-018 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full or holds one entry.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-020 Each TX sequencer SHALL have states IDLE, ARM, BUSY.
REQ-021 IDLE -> ARM when FIFO non-empty and tx_rdy=1; the cycle in ARM pops the FIFO, drives tx_en=1 for exactly one cycle and drives tx_data with the popped byte.
REQ-022 ARM -> BUSY unconditionally; BUSY -> IDLE on the first cycle tx_rdy=1 after tx_rdy=0 has been seen in BUSY.
REQ-023 tx_data SHALL hold the last sent byte until the next ARM.
REQ-024 Bytes SHALL leave each path in arrival order; minimum spacing is one byte per transmitter rdy cycle.
REQ-025 Empty FIFO SHALL keep the sequencer in IDLE with tx_en=0.

Reset
REQ-026 On rst=1: FIFOs empty; sequencers IDLE; t_tx_en=h_tx_en=0; tx_data=8'h00; h_ovf=t_ovf=0; led=0; target_rst_n=1; reset counter 0.
REQ-027 rst asserted mid-transfer SHALL discard all queued bytes; a byte already started in a transmitter is not recalled.
REQ-028 Valid strobes during rst SHALL be ignored.

Configuration
REQ-029 Macro UART_BRIDGE_RST_TRIG_EN defined: each host byte equal to TRIG_BYTE SHALL toggle led, drive target_rst_n=0 starting the next cycle for RST_CYCLES cycles, and still be forwarded to the target.
REQ-030 Trigger during an active pulse SHALL restart the pulse at RST_CYCLES.
REQ-031 A dropped trigger byte (FIFO full) SHALL still trigger the reset pulse.
REQ-032 Macro undefined: target_rst_n=1 constant, led=0 constant, no counter logic; TRIG_BYTE is forwarded as ordinary data.

Structure
REQ-033 Shared package uart_bridge_pkg SHALL hold the byte width (8), the sequencer state encoding and the default TRIG_BYTE.
REQ-034 One sub-module, sync_byte_fifo (parameter DEPTH, push/pop/full/empty/data), SHALL be instantiated once per path.

Verification
REQ-035 Single byte: h_rx 8'h55 with t_tx_rdy=1 -> t_tx_en pulse 2 cycles later, t_tx_data=8'h55.
REQ-036 Backpressure: t_tx_rdy=0, push 16 bytes 0x00..0x0F, then push 0x10 -> h_ovf=1; release rdy -> 0x00..0x0F out in order, 0x10 absent.
REQ-037 Full-FIFO push+pop: FIFO full at DEPTH=16, push in the ARM cycle -> no overflow, occupancy stays 16.
REQ-038 Trigger (macro on, RST_CYCLES=16): host 8'h41 -> target_rst_n low for exactly 16 cycles, led toggles, 8'h41 forwarded; second 8'h41 at pulse cycle 10 -> low 26 cycles total.
REQ-039 Bidirectional: simultaneous h_rx and t_rx streams of 100 random bytes -> both paths lossless and in order.
REQ-040 Mid-operation reset: rst at occupancy 5 -> no further tx_en after reset, all flags 0.
